// File: rtl/coin_input_conditioner.sv
// coin_input_conditioner: debounces coin/button sensors and issues queued one-cycle {x1,x2} codes.
// Optional macro COIN_REJECT_EN adds coin_reject, a pulse per coin event dropped on a full queue.
module coin_input_conditioner #(
   parameter int unsigned DEB_CYCLES = 16,
   parameter int unsigned GAP_CYCLES = 2,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic coin5_raw,
   input  logic coin10_raw,
   input  logic btn_raw,
   output logic x1,
   output logic x2,
   output logic busy,
   output logic ovf
`ifdef COIN_REJECT_EN
   ,
   output logic coin_reject
`endif
);
   localparam int unsigned NSRC = 3;
   localparam int unsigned DW   = $clog2(DEB_CYCLES);
   localparam int unsigned GW   = $clog2(GAP_CYCLES + 1);
   localparam int unsigned AW   = $clog2(FIFO_DEPTH);
   localparam int unsigned CW   = AW + 1;
   // Source order is ten, five, button; codes packed with source 0 in the low bits.
   localparam logic [5:0]  CODES = {2'b11, 2'b01, 2'b10};

   typedef enum logic [1:0] {ST_IDLE, ST_EMIT, ST_GAP} state_t;

   logic [NSRC-1:0] raw_vec;
   logic [NSRC-1:0] sync1_q, sync1_d, sync2_q, sync2_d, deb_q, deb_d;
   logic [DW-1:0]   dcnt_q [NSRC];
   logic [DW-1:0]   dcnt_d [NSRC];
   logic [NSRC-1:0] rise, drop;
   logic [1:0]      mem_q [FIFO_DEPTH];
   logic [1:0]      mem_d [FIFO_DEPTH];
   logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   state_t          state_q, state_d;
   logic [GW-1:0]   gap_q, gap_d;
   logic [1:0]      x_q, x_d;
   logic            busy_q, busy_d, ovf_q, ovf_d;
   logic            gap_done, pop;
   int unsigned     room, n_wr;
`ifdef COIN_REJECT_EN
   logic            rej_q, rej_d;
`endif

   assign raw_vec = {btn_raw, coin5_raw, coin10_raw};

   always_comb begin
      sync1_d = raw_vec;
      sync2_d = sync1_q;
      deb_d   = deb_q;
      // A level is accepted after DEB_CYCLES consecutive samples disagree with it.
      for (int s = 0; s < int'(NSRC); s++) begin
         dcnt_d[s] = '0;
         if (sync2_q[s] != deb_q[s]) begin
            if (dcnt_q[s] == DW'(DEB_CYCLES - 1)) deb_d[s] = ~deb_q[s];
            else                                  dcnt_d[s] = dcnt_q[s] + DW'(1);
         end
      end
      rise = deb_d & ~deb_q;

      gap_done = (gap_q == GW'(GAP_CYCLES - 1));
      pop      = (cnt_q != '0) && ((state_q == ST_IDLE) || ((state_q == ST_GAP) && gap_done));
      state_d  = state_q;
      gap_d    = gap_q;
      rd_d     = rd_q;
      x_d      = 2'b00;
      case (state_q)
         ST_IDLE: state_d = ST_IDLE;
         ST_EMIT: begin
            state_d = ST_GAP;
            gap_d   = '0;
         end
         ST_GAP: begin
            if (gap_done) state_d = ST_IDLE;
            else          gap_d   = gap_q + GW'(1);
         end
         default: state_d = ST_IDLE;
      endcase
      if (pop) begin
         state_d = ST_EMIT;
         x_d     = mem_q[rd_q];
         rd_d    = rd_q + AW'(1);
      end

      // Same-cycle pop frees its slot; late-ordered events are the ones dropped.
      mem_d = mem_q;
      wr_d  = wr_q;
      drop  = '0;
      n_wr  = 0;
      room  = FIFO_DEPTH - 32'(cnt_q) + 32'(pop);
      for (int s = 0; s < int'(NSRC); s++) begin
         if (rise[s]) begin
            if (n_wr < room) begin
               mem_d[wr_d] = CODES[2*s +: 2];
               wr_d        = wr_d + AW'(1);
               n_wr        = n_wr + 1;
            end else begin
               drop[s] = 1'b1;
            end
         end
      end
      cnt_d  = cnt_q + CW'(n_wr) - CW'(pop);
      busy_d = (cnt_d != '0) || (state_d != ST_IDLE);
      ovf_d  = ovf_q | (|drop);
`ifdef COIN_REJECT_EN
      rej_d  = |drop[1:0];
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
         deb_q   <= '0;
         for (int s = 0; s < int'(NSRC); s++) dcnt_q[s] <= '0;
         for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
         cnt_q   <= '0;
         state_q <= ST_IDLE;
         gap_q   <= '0;
         x_q     <= 2'b00;
         busy_q  <= 1'b0;
         ovf_q   <= 1'b0;
`ifdef COIN_REJECT_EN
         rej_q   <= 1'b0;
`endif
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         deb_q   <= deb_d;
         dcnt_q  <= dcnt_d;
         mem_q   <= mem_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         cnt_q   <= cnt_d;
         state_q <= state_d;
         gap_q   <= gap_d;
         x_q     <= x_d;
         busy_q  <= busy_d;
         ovf_q   <= ovf_d;
`ifdef COIN_REJECT_EN
         rej_q   <= rej_d;
`endif
      end
   end

   assign x1   = x_q[1];
   assign x2   = x_q[0];
   assign busy = busy_q;
   assign ovf  = ovf_q;
`ifdef COIN_REJECT_EN
   assign coin_reject = rej_q;
`endif

endmodule

// File: tb/tb_coin_input_conditioner.sv
// Self-checking bench for coin_input_conditioner (DEB_CYCLES=4, GAP_CYCLES=2, FIFO_DEPTH=4)
// against a window-debounce plus event-queue reference model.
module tb_coin_input_conditioner;
   localparam int DEB   = 4;
   localparam int GAP   = 2;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst;
   logic coin5_raw, coin10_raw, btn_raw;
   logic x1, x2, busy, ovf;
`ifdef COIN_REJECT_EN
   logic coin_reject;
`endif

   always #5 clk = ~clk;

   coin_input_conditioner #(
      .DEB_CYCLES(DEB),
      .GAP_CYCLES(GAP),
      .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .coin5_raw  (coin5_raw),
      .coin10_raw (coin10_raw),
      .btn_raw    (btn_raw),
      .x1         (x1),
      .x2         (x2),
      .busy       (busy),
      .ovf        (ovf)
`ifdef COIN_REJECT_EN
      ,
      .coin_reject(coin_reject)
`endif
   );

   int checks   = 0;
   int failures = 0;

   // Reference model: raw delay line, sliding sample window per source, event queue.
   int           k;
   int           next_ok;
   logic [2:0]   r1, r2, deb_m;
   logic [DEB-1:0] win [3];
   logic [1:0]   q [$];
   logic [1:0]   exp_x;
   logic         exp_busy, exp_ovf, exp_rej;

   task automatic model_reset();
      k = 0;
      next_ok = 0;
      r1 = '0;
      r2 = '0;
      deb_m = '0;
      for (int s = 0; s < 3; s++) win[s] = '0;
      q.delete();
      exp_x = 2'b00;
      exp_busy = 1'b0;
      exp_ovf = 1'b0;
      exp_rej = 1'b0;
   endtask

   function automatic logic [1:0] code_of(input int s);
      case (s)
         0:       return 2'b10;
         1:       return 2'b01;
         default: return 2'b11;
      endcase
   endfunction

   task automatic model_edge(input logic [2:0] raw);
      logic [2:0] samp;
      logic [2:0] rise;
      k++;
      samp = r2;
      r2 = r1;
      r1 = raw;
      rise = '0;
      for (int s = 0; s < 3; s++) begin
         win[s] = {win[s][DEB-2:0], samp[s]};
         if (win[s] == {DEB{~deb_m[s]}}) begin
            deb_m[s] = ~deb_m[s];
            rise[s] = deb_m[s];
         end
      end
      exp_x = 2'b00;
      exp_rej = 1'b0;
      if (q.size() != 0 && k >= next_ok) begin
         exp_x = q.pop_front();
         next_ok = k + 1 + GAP;
      end
      for (int s = 0; s < 3; s++) begin
         if (rise[s]) begin
            if (q.size() < DEPTH) q.push_back(code_of(s));
            else begin
               exp_ovf = 1'b1;
               if (s < 2) exp_rej = 1'b1;
            end
         end
      end
      exp_busy = (q.size() != 0) || (k < next_ok);
   endtask

   // raw bit 0 = coin10, bit 1 = coin5, bit 2 = button
   task automatic tick(input logic [2:0] raw);
      coin10_raw = raw[0];
      coin5_raw  = raw[1];
      btn_raw    = raw[2];
      @(posedge clk);
      model_edge(raw);
      @(negedge clk);
   endtask

   task automatic do_reset(input logic [2:0] raw);
      @(negedge clk);
      rst = 1'b0;
      coin10_raw = raw[0];
      coin5_raw  = raw[1];
      btn_raw    = raw[2];
      repeat (3) @(negedge clk);
      rst = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b0;
      coin10_raw = 1'b1;
      coin5_raw  = 1'b1;
      btn_raw    = 1'b1;
      repeat (4) @(negedge clk);
      checks++;
      if ({x1, x2} !== 2'b00) begin
         failures++;
         $display("FAIL reset_x got=%b exp=00", {x1, x2});
      end
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_busy got=%b exp=0", busy);
      end
      checks++;
      if (ovf !== 1'b0) begin
         failures++;
         $display("FAIL reset_ovf got=%b exp=0", ovf);
      end
      do_reset(3'b000);
   endtask

   task automatic test_single_coin10();
      int npulse = 0;
      int at = -1;
      logic [1:0] code = 2'b00;
      do_reset(3'b000);
      for (int i = 1; i <= 20; i++) begin
         tick(3'b001);
         checks++;
         if ({x1, x2} !== exp_x) begin
            failures++;
            $display("FAIL single_x i=%0d got=%b exp=%b", i, {x1, x2}, exp_x);
         end
         checks++;
         if (busy !== exp_busy) begin
            failures++;
            $display("FAIL single_busy i=%0d got=%b exp=%b", i, busy, exp_busy);
         end
         if ({x1, x2} !== 2'b00) begin
            npulse++;
            at = i;
            code = {x1, x2};
         end
      end
      checks++;
      if (npulse != 1 || at != 7 || code !== 2'b10) begin
         failures++;
         $display("FAIL single_pulse count=%0d at=%0d code=%b exp count=1 at=7 code=10", npulse, at, code);
      end
   endtask

   task automatic test_bounce();
      int npulse = 0;
      int early = 0;
      logic [1:0] code = 2'b00;
      logic [2:0] raw;
      do_reset(3'b000);
      for (int i = 1; i <= 26; i++) begin
         raw = (i <= 6) ? {1'b0, 1'(i % 2), 1'b0} : 3'b010;
         tick(raw);
         checks++;
         if ({x1, x2} !== exp_x) begin
            failures++;
            $display("FAIL bounce_x i=%0d got=%b exp=%b", i, {x1, x2}, exp_x);
         end
         if ({x1, x2} !== 2'b00) begin
            npulse++;
            code = {x1, x2};
            if (i <= 8) early++;
         end
      end
      checks++;
      if (npulse != 1 || early != 0 || code !== 2'b01) begin
         failures++;
         $display("FAIL bounce_pulse count=%0d early=%0d code=%b exp count=1 early=0 code=01", npulse, early, code);
      end
   endtask

   task automatic test_simultaneous();
      logic [1:0] got [$];
      int bfirst = -1;
      int blast = -1;
      do_reset(3'b000);
      for (int i = 1; i <= 22; i++) begin
         tick(3'b111);
         checks++;
         if ({x1, x2} !== exp_x) begin
            failures++;
            $display("FAIL simul_x i=%0d got=%b exp=%b", i, {x1, x2}, exp_x);
         end
         checks++;
         if (busy !== exp_busy) begin
            failures++;
            $display("FAIL simul_busy i=%0d got=%b exp=%b", i, busy, exp_busy);
         end
         if ({x1, x2} !== 2'b00) got.push_back({x1, x2});
         if (busy === 1'b1) begin
            if (bfirst < 0) bfirst = i;
            blast = i;
         end
      end
      checks++;
      if (got.size() != 3) begin
         failures++;
         $display("FAIL simul_count got=%0d exp=3", got.size());
      end else if (got[0] !== 2'b10 || got[1] !== 2'b01 || got[2] !== 2'b11) begin
         failures++;
         $display("FAIL simul_order got=%b,%b,%b exp=10,01,11", got[0], got[1], got[2]);
      end
      checks++;
      if (bfirst != 6 || blast != 15) begin
         failures++;
         $display("FAIL simul_busy_window got=%0d..%0d exp=6..15", bfirst, blast);
      end
   endtask

   task automatic test_overflow();
      logic [2:0] raw;
      do_reset(3'b000);
      for (int i = 1; i <= 160; i++) begin
         raw[2] = ((i - 1) % 8) < 4;
         raw[1] = ((i + 3) % 8) < 4;
         raw[0] = raw[1];
         tick(raw);
         checks++;
         if ({x1, x2} !== exp_x) begin
            failures++;
            $display("FAIL ovf_x i=%0d got=%b exp=%b", i, {x1, x2}, exp_x);
         end
         checks++;
         if (busy !== exp_busy || ovf !== exp_ovf) begin
            failures++;
            $display("FAIL ovf_flags i=%0d got busy=%b ovf=%b exp busy=%b ovf=%b", i, busy, ovf, exp_busy, exp_ovf);
         end
`ifdef COIN_REJECT_EN
         checks++;
         if (coin_reject !== exp_rej) begin
            failures++;
            $display("FAIL ovf_reject i=%0d got=%b exp=%b", i, coin_reject, exp_rej);
         end
`endif
      end
      checks++;
      if (ovf !== 1'b1) begin
         failures++;
         $display("FAIL ovf_sticky got=%b exp=1", ovf);
      end
   endtask

   task automatic test_reset_mid_emit();
      int found = 0;
      int npulse = 0;
      for (int i = 0; i < 20 && found == 0; i++) begin
         tick(3'b000);
         if (exp_x != 2'b00) found = 1;
      end
      checks++;
      if (found == 0 || {x1, x2} === 2'b00) begin
         failures++;
         $display("FAIL mid_emit_setup found=%0d x=%b exp nonzero", found, {x1, x2});
      end
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if ({x1, x2} !== 2'b00 || busy !== 1'b0 || ovf !== 1'b0) begin
         failures++;
         $display("FAIL mid_emit_reset got x=%b busy=%b ovf=%b exp 00/0/0", {x1, x2}, busy, ovf);
      end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      model_reset();
      for (int i = 1; i <= 30; i++) begin
         tick(3'b000);
         checks++;
         if ({x1, x2} !== exp_x || busy !== exp_busy) begin
            failures++;
            $display("FAIL mid_emit_after i=%0d got x=%b busy=%b exp x=%b busy=%b", i, {x1, x2}, busy, exp_x, exp_busy);
         end
         if ({x1, x2} !== 2'b00) npulse++;
      end
      checks++;
      if (npulse != 0) begin
         failures++;
         $display("FAIL mid_emit_leftover got=%0d exp=0", npulse);
      end
   endtask

   task automatic test_high_through_reset();
      int npulse = 0;
      int at = -1;
      do_reset(3'b001);
      for (int i = 1; i <= 20; i++) begin
         tick(3'b001);
         checks++;
         if ({x1, x2} !== exp_x) begin
            failures++;
            $display("FAIL hold_x i=%0d got=%b exp=%b", i, {x1, x2}, exp_x);
         end
         if ({x1, x2} === 2'b10) begin
            npulse++;
            at = i;
         end
      end
      checks++;
      if (npulse != 1 || at != 7) begin
         failures++;
         $display("FAIL hold_pulse count=%0d at=%0d exp count=1 at=7", npulse, at);
      end
   endtask

   task automatic test_random();
      logic [2:0] raw = '0;
      do_reset(3'b000);
      for (int i = 1; i <= 800; i++) begin
         for (int s = 0; s < 3; s++)
            if ($urandom_range(0, 5) == 0) raw[s] = ~raw[s];
         tick(raw);
         checks++;
         if ({x1, x2} !== exp_x) begin
            failures++;
            $display("FAIL rand_x i=%0d got=%b exp=%b", i, {x1, x2}, exp_x);
         end
         checks++;
         if (busy !== exp_busy || ovf !== exp_ovf) begin
            failures++;
            $display("FAIL rand_flags i=%0d got busy=%b ovf=%b exp busy=%b ovf=%b", i, busy, ovf, exp_busy, exp_ovf);
         end
`ifdef COIN_REJECT_EN
         checks++;
         if (coin_reject !== exp_rej) begin
            failures++;
            $display("FAIL rand_reject i=%0d got=%b exp=%b", i, coin_reject, exp_rej);
         end
`endif
      end
   endtask

   initial begin
      rst = 1'b0;
      coin10_raw = 1'b0;
      coin5_raw  = 1'b0;
      btn_raw    = 1'b0;
      model_reset();
      test_reset();
      test_single_coin10();
      test_bounce();
      test_simultaneous();
      test_overflow();
      test_reset_mid_emit();
      test_high_through_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
